vga_pixel_fetch: RTL

//  Upstream pixel source for the VGA timing stage. It streams one frame of 9-bit RGB pixels
//  (H_RES*V_RES, raster order) out of framebuffer memory and buffers them in a small FIFO.
//  It presents one pixel on RGB for every active-display strobe from the timing stage.

---
 rtl/vga_pixel_fetch.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// ----------------------------------------------------------------------------
// vga_pixel_fetch
//   Streams one frame of 9-bit RGB pixels (H_RES*V_RES, raster order) out of
//   framebuffer memory into a small pixel FIFO. One pixel is presented on RGB
//   for every pix_en strobe from the VGA timing stage.
//
//   Optional feature: define VGA_FETCH_STATS_EN to add the underflow_cnt port.
//
// Ports
//   clk_25        pixel clock
//   rst           asynchronous, active-high reset
//   frame_start   1-cycle pulse, new frame begins (restarts fetching)
//   pix_en        timing stage consumes a pixel this cycle
//   fb_base       frame base word address, sampled on frame_start
//   mem_req       read request, held with mem_addr until mem_ack
//   mem_addr      read word address
//   mem_ack       request accepted this cycle
//   mem_rvalid    read data valid (in request order, latency >= 1)
//   mem_rdata     read data {R[2:0],G[2:0],B[2:0]}
//   RGB           pixel to timing stage (registered)
//   underflow     1-cycle pulse, pix_en seen while FIFO empty
//   fifo_level    current FIFO occupancy
//   busy          high while fetching or draining outstanding reads
//   underflow_cnt (VGA_FETCH_STATS_EN only) saturating underflow count
// ----------------------------------------------------------------------------
module vga_pixel_fetch #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [8:0]  BG_COLOR   = 9'h000
) (
    input  logic                          clk_25,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          pix_en,
    input  logic [ADDR_W-1:0]             fb_base,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic                          mem_rvalid,
    input  logic [8:0]                    mem_rdata,
    output logic [8:0]                    RGB,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0]                   underflow_cnt
`endif
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned SUM_W  = LVL_W + 1;
    localparam int unsigned TOTAL  = H_RES * V_RES;
    localparam int unsigned IDX_W  = $clog2(TOTAL + 1);
    localparam int unsigned DISC_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]   fb_base_q, fb_base_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [LVL_W-1:0]    outstanding_q, outstanding_d;
    logic [DISC_W-1:0]   discard_q, discard_d;
    logic                stale_q, stale_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [8:0]          rgb_q, rgb_d;
    logic                underflow_q, underflow_d;
    logic                busy_q, busy_d;

    logic                ack;
    logic                pop;
    logic                push;
    logic [DISC_W-1:0]   disc_sum;

    logic [8:0]          fifo_mem [FIFO_DEPTH];

    assign ack = mem_req_q && mem_ack;

    // Next-state: FSM, request issue, in-flight/discard accounting, FIFO and output.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        fb_base_d     = fb_base_q;
        index_d       = index_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        stale_d       = stale_q;
        level_d       = level_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        rgb_d         = rgb_q;
        push          = 1'b0;
        disc_sum      = '0;

        // Output stage always sees the pre-flush FIFO, even on frame_start.
        pop         = pix_en && (level_q != '0);
        underflow_d = pix_en && (level_q == '0);
        if (pop) begin
            rgb_d = fifo_mem[rd_ptr_q];
        end else if (underflow_d) begin
            rgb_d = BG_COLOR;
        end

        if (frame_start) begin
            // Everything still in flight (including an ack this cycle) becomes
            // stale; a return arriving this very cycle is already dropped.
            disc_sum      = discard_q + DISC_W'(outstanding_q) + DISC_W'(ack);
            discard_d     = (mem_rvalid && (disc_sum != '0)) ? disc_sum - DISC_W'(1) : disc_sum;
            outstanding_d = '0;
            index_d       = '0;
            fb_base_d     = fb_base;
            level_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            // A request still waiting for its ack belongs to the old frame.
            stale_d       = mem_req_q && !mem_ack;
            state_d       = S_FETCH;
        end else begin
            if (ack) begin
                if (stale_q) begin
                    discard_d = discard_q + DISC_W'(1);
                    stale_d   = 1'b0;
                end else begin
                    outstanding_d = outstanding_q + LVL_W'(1);
                    index_d       = index_q + IDX_W'(1);
                end
            end

            // Returns retire stale reads first; strays with nothing in flight are ignored.
            if (mem_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_d - DISC_W'(1);
                end else if (outstanding_q != '0) begin
                    push          = 1'b1;
                    outstanding_d = outstanding_d - LVL_W'(1);
                end
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);

            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FETCH: begin
                    if (index_d == IDX_W'(TOTAL)) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (outstanding_q == '0) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // A pending request is never withdrawn; a new one is issued only when
        // buffered plus in-flight pixels leave room for its data.
        if (mem_req_q && !mem_ack) begin
            mem_req_d = 1'b1;
        end else if ((state_d == S_FETCH) && (index_d < IDX_W'(TOTAL)) &&
                     ((SUM_W'(level_d) + SUM_W'(outstanding_d)) < SUM_W'(FIFO_DEPTH))) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fb_base_d + ADDR_W'(index_d);
        end else begin
            mem_req_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            fb_base_q     <= '0;
            index_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            stale_q       <= 1'b0;
            level_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rgb_q         <= BG_COLOR;
            underflow_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            fb_base_q     <= fb_base_d;
            index_q       <= index_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            stale_q       <= stale_d;
            level_q       <= level_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rgb_q         <= rgb_d;
            underflow_q   <= underflow_d;
            busy_q        <= busy_d;
        end
    end

    // Pixel storage; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk_25) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign RGB        = rgb_q;
    assign underflow  = underflow_q;
    assign fifo_level = level_q;
    assign busy       = busy_q;

`ifdef VGA_FETCH_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Saturating underflow counter; a pulse coinciding with frame_start counts as 1.
    always_comb begin
        ucnt_d = ucnt_q;
        if (frame_start) begin
            ucnt_d = underflow_d ? 16'd1 : 16'd0;
        end else if (underflow_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule
